// File: rtl/digital_mem_responder_pkg.sv
// Shared constants for the memory responder: FSM state encoding, the default
// base address of word 0, and the data width / byte-lane count.
// Ports: none (package).
package digital_mem_responder_pkg;

  typedef enum logic [1:0] {
    MEMR_IDLE = 2'd0,
    MEMR_WAIT = 2'd1,
    MEMR_RESP = 2'd2,
    MEMR_HOLD = 2'd3
  } memr_state_t;

  localparam int          MEMR_XLEN      = 32;
  localparam int          MEMR_LANES     = MEMR_XLEN / 8;
  localparam logic [31:0] MEMR_BASE_ADDR = 32'h8000_0000;

endpackage

// File: rtl/digital_mem_responder_mem_lane_ram.sv
// Single-port word RAM: synchronous write with a per-byte mask, combinational read.
// Ports: clk; we/addr/be/wdata write side (one word per cycle); rdata = mem[addr].
// Kept apart from the FSM so it can be replaced by a block-RAM macro.
module mem_lane_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      addr,
  input  logic [WIDTH/8-1:0] be,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int n = 0; n < WIDTH / 8; n++) begin
        if (be[n]) mem[addr][8*n +: 8] <= wdata[8*n +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/digital_mem_responder.sv
// Memory-side responder: services level-held read/write requests from an
// internal word array after WAIT_CYCLES wait states, then pulses ready once.
// Ports: clk, rst (sync, active-low); request addr/write_en/read_en/byte_size/
// wdata; response digital_mem_data, digital_mem_ready, mem_access_err.
module digital_mem_responder
  import digital_mem_responder_pkg::*;
#(
  parameter int               XLEN        = MEMR_XLEN,
  parameter int               DEPTH_WORDS = 4096,
  parameter logic [XLEN-1:0]  BASE_ADDR   = MEMR_BASE_ADDR,
  parameter int               WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   digital_mem_addr,
  input  logic              digital_mem_write_en,
  input  logic              digital_mem_read_en,
  input  logic [3:0]        digital_mem_byte_size,
  input  logic [XLEN-1:0]   digital_mem_wdata,
  output logic [XLEN-1:0]   digital_mem_data,
  output logic              digital_mem_ready,
  output logic              mem_access_err
);

  localparam int LANES = XLEN / 8;
  localparam int AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW    = $clog2(WAIT_CYCLES + 2);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES);
  // With zero wait states the request goes straight to the access cycle.
  localparam memr_state_t FIRST_STATE = (WAIT_CYCLES == 0) ? MEMR_RESP : MEMR_WAIT;

  memr_state_t       state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [XLEN-1:0]   req_addr, req_wdata;
  logic [LANES-1:0]  req_mask;
  logic              req_wr, req_bad;
  logic              accept;
  logic [XLEN-1:0]   offset;
  logic              in_range;
  logic [XLEN-1:0]   lane_bits;
  logic [XLEN-1:0]   ram_rdata;
  logic              ram_we;
  logic [XLEN-1:0]   data_nxt;
  logic              ready_nxt, err_nxt;

  assign accept = (state == MEMR_IDLE) && (digital_mem_read_en || digital_mem_write_en);

  // Unsigned subtract: addresses below the base wrap high and fall out of range.
  assign offset   = req_addr - BASE_ADDR;
  assign in_range = (offset >> 2) < XLEN'(DEPTH_WORDS);

  always_comb begin
    lane_bits = '0;
    for (int n = 0; n < LANES; n++) lane_bits[8*n +: 8] = {8{req_mask[n]}};
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = digital_mem_data;
    ready_nxt = 1'b0;
    err_nxt   = 1'b0;
    ram_we    = 1'b0;
    case (state)
      MEMR_IDLE: begin
        if (accept) begin
          cnt_nxt   = WAIT_LOAD;
          state_nxt = FIRST_STATE;
        end
      end
      MEMR_WAIT: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) state_nxt = MEMR_RESP;
      end
      MEMR_RESP: begin
        ready_nxt = 1'b1;
        state_nxt = MEMR_HOLD;
        if (req_bad || !in_range) begin
          err_nxt  = 1'b1;
          data_nxt = '0;
        end else if (req_wr) begin
          ram_we = 1'b1;
        end else begin
          data_nxt = ram_rdata & lane_bits;
        end
      end
      MEMR_HOLD: begin
        // Wait for the requester to drop its level-held enable.
        if (!digital_mem_read_en && !digital_mem_write_en) state_nxt = MEMR_IDLE;
      end
      default: state_nxt = MEMR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= MEMR_IDLE;
      cnt               <= '0;
      digital_mem_data  <= '0;
      digital_mem_ready <= 1'b0;
      mem_access_err    <= 1'b0;
      req_addr          <= '0;
      req_wdata         <= '0;
      req_mask          <= '0;
      req_wr            <= 1'b0;
      req_bad           <= 1'b0;
    end else begin
      state             <= state_nxt;
      cnt               <= cnt_nxt;
      digital_mem_data  <= data_nxt;
      digital_mem_ready <= ready_nxt;
      mem_access_err    <= err_nxt;
      if (accept) begin
        req_addr  <= digital_mem_addr;
        req_wdata <= digital_mem_wdata;
        req_mask  <= digital_mem_byte_size[LANES-1:0];
        req_wr    <= digital_mem_write_en;
        req_bad   <= digital_mem_write_en && digital_mem_read_en;
      end
    end
  end

  // Gating with rst keeps a reset landing on the access cycle from committing the write.
  mem_lane_ram #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we && rst),
    .addr  (offset[AW+1:2]),
    .be    (req_mask),
    .wdata (req_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_digital_mem_responder.sv
// Bench for digital_mem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
// Requests push expected responses (data, err, arrival cycle) onto a per-instance queue;
// a negedge monitor pops and compares on every ready pulse.
module tb_digital_mem_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // instance 0: WAIT_CYCLES=2
  logic        a_rst, a_we, a_re, a_rdy, a_err;
  logic [31:0] a_addr, a_wd, a_data;
  logic [3:0]  a_bs;
  // instance 1: WAIT_CYCLES=0
  logic        b_rst, b_we, b_re, b_rdy, b_err;
  logic [31:0] b_addr, b_wd, b_data;
  logic [3:0]  b_bs;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] last_data [2];

  digital_mem_responder #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(a_rst), .digital_mem_addr(a_addr), .digital_mem_write_en(a_we),
    .digital_mem_read_en(a_re), .digital_mem_byte_size(a_bs), .digital_mem_wdata(a_wd),
    .digital_mem_data(a_data), .digital_mem_ready(a_rdy), .mem_access_err(a_err)
  );

  digital_mem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(b_rst), .digital_mem_addr(b_addr), .digital_mem_write_en(b_we),
    .digital_mem_read_en(b_re), .digital_mem_byte_size(b_bs), .digital_mem_wdata(b_wd),
    .digital_mem_data(b_data), .digital_mem_ready(b_rdy), .mem_access_err(b_err)
  );

  task automatic drive(input int s, input logic re, input logic we,
                       input logic [31:0] addr, input logic [3:0] m, input logic [31:0] wd);
    if (s == 0) begin a_re = re; a_we = we; a_addr = addr; a_bs = m; a_wd = wd; end
    else        begin b_re = re; b_we = we; b_addr = addr; b_bs = m; b_wd = wd; end
  endtask

  task automatic check_resp(input int s, input logic [31:0] d, input logic e);
    exp_t x;
    checks++;
    if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL unexpected_ready dut%0d cyc=%0d: got ready=1 data=%h err=%b, required no pulse",
               s, cyc, d, e);
      return;
    end
    x = (s == 0) ? q0.pop_front() : q1.pop_front();
    if (d !== x.data || e !== x.err || cyc != x.due) begin
      errors++;
      $display("FAIL resp dut%0d: got data=%h err=%b cyc=%0d, required data=%h err=%b cyc=%0d",
               s, d, e, cyc, x.data, x.err, x.due);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (a_rdy === 1'b1) check_resp(0, a_data, a_err);
    if (b_rdy === 1'b1) check_resp(1, b_data, b_err);
    if (a_err === 1'b1 && a_rdy !== 1'b1) begin
      checks++; errors++;
      $display("FAIL err_without_ready dut0 cyc=%0d: got err=1 ready=0, required err only with ready", cyc);
    end
  end

  // kind: 0 read, 1 write, 2 read+write together. hold = extra cycles enables stay high after ready.
  task automatic req(input int s, input int kind, input logic [31:0] addr, input logic [3:0] m,
                     input logic [31:0] wd, input logic [31:0] rd_exp, input logic exp_err,
                     input int hold);
    exp_t x;
    logic got;
    @(negedge clk);
    drive(s, kind != 1, kind != 0, addr, m, wd);
    x.err  = exp_err;
    x.data = exp_err ? 32'h0 : ((kind == 1) ? last_data[s] : rd_exp);
    x.due  = cyc + 2 + ((s == 0) ? 2 : 0);
    last_data[s] = x.data;
    if (s == 0) q0.push_back(x); else q1.push_back(x);
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = (s == 0) ? a_rdy : b_rdy;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL timeout dut%0d addr=%h: got no ready in 20 cycles, required ready", s, addr);
      if (s == 0 && q0.size() > 0) void'(q0.pop_back());
      if (s == 1 && q1.size() > 0) void'(q1.pop_back());
    end
    repeat (hold) @(negedge clk);
    drive(s, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  initial begin
    a_rst = 1'b0; b_rst = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    last_data[0] = 32'h0; last_data[1] = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (a_rdy !== 1'b0 || a_err !== 1'b0 || a_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_dut0: got ready=%b err=%b data=%h, required 0 0 00000000", a_rdy, a_err, a_data);
    end
    checks++;
    if (b_rdy !== 1'b0 || b_err !== 1'b0 || b_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_dut1: got ready=%b err=%b data=%h, required 0 0 00000000", b_rdy, b_err, b_data);
    end
    a_rst = 1'b1; b_rst = 1'b1;

    // 1: full write, read-back; index 0 and two other words given known contents
    req(0, 1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
    req(0, 0, 32'h8000_0010, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
    req(0, 1, 32'h8000_0000, 4'hF, 32'h0102_0304, 32'h0, 1'b0, 0);
    req(0, 1, 32'h8000_0020, 4'hF, 32'h1122_3344, 32'h0, 1'b0, 0);
    req(0, 1, 32'h8000_0030, 4'hF, 32'h0000_0000, 32'h0, 1'b0, 0);

    // 2: byte-lane write and masked reads
    req(0, 1, 32'h8000_0010, 4'b0010, 32'h0000_AA00, 32'h0, 1'b0, 0);
    req(0, 0, 32'h8000_0010, 4'hF, 32'h0, 32'hDEAD_AAEF, 1'b0, 0);
    req(0, 0, 32'h8000_0010, 4'b1100, 32'h0, 32'hDEAD_0000, 1'b0, 0);
    req(0, 0, 32'h8000_0013, 4'b0000, 32'h0, 32'h0000_0000, 1'b0, 0);

    // 3: out-of-range on both sides, then a good read of index 0
    req(0, 0, 32'h7FFF_FFFC, 4'hF, 32'h0, 32'h0, 1'b1, 0);
    req(0, 0, 32'h8000_4000, 4'hF, 32'h0, 32'h0, 1'b1, 0);
    req(0, 0, 32'h8000_0000, 4'hF, 32'h0, 32'h0102_0304, 1'b0, 0);
    req(0, 1, 32'h8000_4000, 4'hF, 32'h5555_5555, 32'h0, 1'b1, 0);
    req(0, 0, 32'h8000_3FFC, 4'h0, 32'h0, 32'h0, 1'b0, 0);

    // 4: enable held 10 cycles after ready gives one pulse; re-request gives another
    req(0, 0, 32'h8000_0010, 4'hF, 32'h0, 32'hDEAD_AAEF, 1'b0, 10);
    req(0, 0, 32'h8000_0010, 4'hF, 32'h0, 32'hDEAD_AAEF, 1'b0, 0);

    // 5: read and write together is an error and leaves storage alone
    req(0, 2, 32'h8000_0020, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
    req(0, 0, 32'h8000_0020, 4'hF, 32'h0, 32'h1122_3344, 1'b0, 0);

    // 6: reset during the wait states aborts the write without a ready pulse
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h8000_0030, 4'hF, 32'hCAFE_F00D);
    repeat (2) @(negedge clk);
    a_rst = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (a_rdy !== 1'b0 || a_err !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_reset: got ready=%b err=%b, required 0 0", a_rdy, a_err);
      end
    end
    a_rst = 1'b1;
    last_data[0] = 32'h0;
    req(0, 0, 32'h8000_0030, 4'hF, 32'h0, 32'h0000_0000, 1'b0, 0);
    req(0, 0, 32'h8000_0010, 4'hF, 32'h0, 32'hDEAD_AAEF, 1'b0, 0);

    // zero wait states: ready on the cycle after acceptance
    req(1, 1, 32'h8000_0030, 4'hF, 32'h0000_0000, 32'h0, 1'b0, 0);
    req(1, 1, 32'h8000_0034, 4'hF, 32'hA5A5_5A5A, 32'h0, 1'b0, 0);
    req(1, 0, 32'h8000_0030, 4'hF, 32'h0, 32'h0000_0000, 1'b0, 0);
    req(1, 0, 32'h8000_0034, 4'b0101, 32'h0, 32'h00A5_005A, 1'b0, 0);
    req(1, 0, 32'h8000_4000, 4'hF, 32'h0, 32'h0, 1'b1, 0);

    repeat (5) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: got q0=%0d q1=%0d pending, required 0 0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
